// File: rtl/rgb_to_gray_sum_sat_if.sv
// rgb_to_gray_sum_sat_if: product-in / gray-out stream bundle; m_data widens to 24 bits under GRAY_RGB888_OUT_EN
interface rgb_to_gray_sum_sat_if #(
  parameter int PROD_W = 23,
`ifdef GRAY_RGB888_OUT_EN
  parameter int DATA_W = 24
`else
  parameter int DATA_W = 8
`endif
);
  logic [PROD_W-1:0] s_prod_r, s_prod_g, s_prod_b;
  logic s_valid, s_last, s_user, s_ready;
  logic [DATA_W-1:0] m_data;
  logic m_valid, m_last, m_user, m_ready;
  modport slave (
    input s_prod_r, s_prod_g, s_prod_b, s_valid, s_last, s_user, m_ready,
    output s_ready, m_data, m_valid, m_last, m_user
  );
  modport master (
    output s_prod_r, s_prod_g, s_prod_b, s_valid, s_last, s_user, m_ready,
    input s_ready, m_data, m_valid, m_last, m_user
  );
endinterface

// File: rtl/rgb_to_gray_sum_sat.sv
// rgb_to_gray_sum_sat: sum/round/saturate RGB products to gray on a 2-stage stream; GRAY_RGB888_OUT_EN replicates gray to 24 bits
module rgb_to_gray_sum_sat #(
  parameter int PROD_W = 23,
  parameter int FRAC_SHIFT = 15,
  parameter int SATCNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  rgb_to_gray_sum_sat_if.slave io,
  output logic [SATCNT_W-1:0] sat_count
);
  localparam int SUM_W = PROD_W + 3;
  localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_SHIFT - 1);
  logic adv1, adv2, sat;
  logic [SUM_W-1:0] rnd;
  logic [7:0] g8;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_user_q, s1_user_d;
  logic [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, m_user_q, m_user_d;
  logic [7:0] m_data_q, m_data_d;
  logic [SATCNT_W-1:0] sat_count_q, sat_count_d;
  always_comb begin
    adv2 = !m_valid_q || io.m_ready;
    adv1 = !s1_valid_q || adv2;
    rnd = (s1_sum_q + HALF) >> FRAC_SHIFT;
    sat = rnd > SUM_W'(255);
    g8 = sat ? 8'hFF : rnd[7:0];
    s1_valid_d = adv1 ? io.s_valid : s1_valid_q;
    s1_sum_d = adv1 ? SUM_W'(io.s_prod_r) + SUM_W'(io.s_prod_g) + SUM_W'(io.s_prod_b) : s1_sum_q;
    s1_last_d = adv1 ? io.s_last : s1_last_q;
    s1_user_d = adv1 ? io.s_user : s1_user_q;
    m_valid_d = adv2 ? s1_valid_q : m_valid_q;
    m_data_d = adv2 ? g8 : m_data_q;
    m_last_d = adv2 ? s1_last_q : m_last_q;
    m_user_d = adv2 ? s1_user_q : m_user_q;
    // count moves on the S2 load of a valid pixel, a frame start restarts it
    sat_count_d = !(adv2 && s1_valid_q) ? sat_count_q :
                  s1_user_q ? SATCNT_W'(sat) :
                  (sat && !(&sat_count_q)) ? sat_count_q + SATCNT_W'(1) : sat_count_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q <= '0;
      s1_last_q <= 1'b0;
      s1_user_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      m_user_q <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q <= s1_sum_d;
      s1_last_q <= s1_last_d;
      s1_user_q <= s1_user_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
      m_user_q <= m_user_d;
      sat_count_q <= sat_count_d;
    end
  end
  assign io.s_ready = adv1;
  assign io.m_valid = m_valid_q;
  assign io.m_last = m_last_q;
  assign io.m_user = m_user_q;
  assign sat_count = sat_count_q;
`ifdef GRAY_RGB888_OUT_EN
  assign io.m_data = {3{m_data_q}};
`else
  assign io.m_data = m_data_q;
`endif
endmodule
